// File: rtl/btn_pkg.sv
// Shared constants and state encoding for the button event block.
// Defaults live here so the top level and benches agree on them.
package btn_pkg;

  localparam int HOLD_CYCLES_DEF   = 50_000_000;
  localparam int REPEAT_CYCLES_DEF = 10_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_if.sv
// Button level in, one-cycle event pulses and held level out.
// slave: the event block; master: whoever drives the level.
interface btn_event_if;

  logic btn_status_i;
  logic press_o;
  logic release_o;
  logic long_press_o;
  logic repeat_o;
  logic held_o;

  modport slave (
    input  btn_status_i,
    output press_o,
    output release_o,
    output long_press_o,
    output repeat_o,
    output held_o
  );

  modport master (
    output btn_status_i,
    input  press_o,
    input  release_o,
    input  long_press_o,
    input  repeat_o,
    input  held_o
  );

endinterface

// File: rtl/btn_event.sv
// Debounced level -> press/release/long-press/repeat pulses.
// Ports: clk, rst_n (sync, active low), bus (btn_event_if.slave).
module btn_event
  import btn_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  btn_event_if.slave  bus
);

  localparam int CNT_W =
    $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST =
    CNT_W'(REPEAT_CYCLES - 1);

  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;
  logic             rpt_q;
  logic             held_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rpt_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rpt_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.btn_status_i) begin
            state_q <= PRESSED;
            press_q <= 1'b1;
            held_q  <= 1'b1;
          end
        end
        PRESSED: begin
          // release is tested first so it wins at the threshold
          if (!bus.btn_status_i) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt_q     <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= REPEAT;
            long_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!bus.btn_status_i) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt_q     <= '0;
          end else if (cnt_q == RPT_LAST) begin
            rpt_q <= 1'b1;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // encoding 3 is unreachable; fall back to a clean idle
          state_q <= IDLE;
          cnt_q   <= '0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_o      = press_q;
  assign bus.release_o    = release_q;
  assign bus.long_press_o = long_q;
  assign bus.repeat_o     = rpt_q;
  assign bus.held_o       = held_q;

endmodule
